// File: rtl/flash_arb_pkg.sv
// -----------------------------------------------------------------------------
// flash_arb_pkg
// Shared definitions for the flash arbiter slice.
//   arb_state_t            : arbiter FSM state encoding
//   PORT0 / PORT1          : requester port indices (0 = UART manager,
//                            1 = display scanner)
//   DEFAULT_TIMEOUT_CYCLES : default flash wait-state watchdog limit in clocks
// -----------------------------------------------------------------------------
package flash_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam logic [15:0] DEFAULT_TIMEOUT_CYCLES = 16'd50000;

endpackage

// File: rtl/flash_arb_if.sv
// -----------------------------------------------------------------------------
// flash_arb_if
// Bundles the two requester ports and the flash driver handshake.
//   Requesters : REQx, FLOWx (1 = write), ADDRx, WDATAx -> GNTx, DONEx
//   Shared     : RDATA, ERR, BUSY
//   Driver     : FL_ADDR, FL_FLOW, fl_data_out, FL_TRG -> FL_STATUS, fl_data_in
// modport slave  : the arbiter side
// modport master : the environment (requesters + flash driver)
// -----------------------------------------------------------------------------
interface flash_arb_if;

    logic       REQ0;
    logic       REQ1;
    logic       FLOW0;
    logic       FLOW1;
    logic [7:0] ADDR0;
    logic [7:0] ADDR1;
    logic [7:0] WDATA0;
    logic [7:0] WDATA1;
    logic       GNT0;
    logic       GNT1;
    logic       DONE0;
    logic       DONE1;
    logic [7:0] RDATA;
    logic       ERR;
    logic       BUSY;
    logic [7:0] FL_ADDR;
    logic       FL_FLOW;
    logic [7:0] fl_data_out;
    logic       FL_TRG;
    logic       FL_STATUS;
    logic [7:0] fl_data_in;

    modport slave (
        input  REQ0, REQ1, FLOW0, FLOW1, ADDR0, ADDR1, WDATA0, WDATA1,
        input  FL_STATUS, fl_data_in,
        output GNT0, GNT1, DONE0, DONE1, RDATA, ERR, BUSY,
        output FL_ADDR, FL_FLOW, fl_data_out, FL_TRG
    );

    modport master (
        output REQ0, REQ1, FLOW0, FLOW1, ADDR0, ADDR1, WDATA0, WDATA1,
        output FL_STATUS, fl_data_in,
        input  GNT0, GNT1, DONE0, DONE1, RDATA, ERR, BUSY,
        input  FL_ADDR, FL_FLOW, fl_data_out, FL_TRG
    );

endinterface

// File: rtl/flash_arb_wdog.sv
// -----------------------------------------------------------------------------
// flash_arb_wdog
// Wait-state watchdog counter for the flash arbiter.
//   clk, rst : clock, synchronous active-low reset
//   clear    : zero the counter (has priority over enable)
//   enable   : count up by one this cycle
//   expired  : counter has reached TIMEOUT_CYCLES-1
// -----------------------------------------------------------------------------
module flash_arb_wdog
    import flash_arb_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [15:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 16'd1;
        end
    end

    assign expired = (count == (TIMEOUT_CYCLES - 16'd1));

endmodule

// File: rtl/flash_arbiter.sv
// -----------------------------------------------------------------------------
// flash_arbiter
// Round-robin arbiter giving two requesters (UART manager, display scanner)
// exclusive access to a single flash driver, one transaction at a time.
//   CLK_50MHZ : sole clock, rising edge
//   RST       : synchronous active-low reset
//   bus       : flash_arb_if.slave -- requester ports, shared status and the
//               flash driver handshake
// Parameter TIMEOUT_CYCLES bounds the WAIT state; on expiry the transaction is
// completed with RDATA = 8'hFF and a one-cycle ERR pulse alongside DONEx.
// -----------------------------------------------------------------------------
module flash_arbiter
    import flash_arb_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        CLK_50MHZ,
    input  logic        RST,
    flash_arb_if.slave  bus
);

    arb_state_t state;
    arb_state_t state_n;

    logic       owner;
    logic       last;
    logic       err_flag;
    logic       gnt0;
    logic       gnt1;
    logic [7:0] rdata;
    logic [7:0] fl_addr;
    logic       fl_flow;
    logic [7:0] fl_wdata;

    logic       grant;
    logic       winner;
    logic       capture;
    logic       timeout;
    logic       wd_clear;
    logic       wd_enable;
    logic       wd_expired;

    flash_arb_wdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk     (CLK_50MHZ),
        .rst     (RST),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_ff @(posedge CLK_50MHZ) begin
        if (!RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        grant     = 1'b0;
        winner    = PORT0;
        capture   = 1'b0;
        timeout   = 1'b0;
        wd_clear  = 1'b0;
        wd_enable = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.REQ0 || bus.REQ1) begin
                    grant   = 1'b1;
                    // Under contention the port not served last wins.
                    winner  = (bus.REQ0 && bus.REQ1) ? ~last : bus.REQ1;
                    state_n = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wd_clear = 1'b1;
                state_n  = ST_WAIT;
            end
            ST_WAIT: begin
                wd_enable = 1'b1;
                // A driver completion on the final watchdog cycle still counts.
                if (bus.FL_STATUS) begin
                    capture = 1'b1;
                    state_n = ST_DONE;
                end else if (wd_expired) begin
                    timeout = 1'b1;
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_50MHZ) begin
        if (!RST) begin
            owner    <= PORT0;
            last     <= PORT1;
            err_flag <= 1'b0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            rdata    <= '0;
            fl_addr  <= '0;
            fl_flow  <= 1'b0;
            fl_wdata <= '0;
        end else begin
            if (grant) begin
                owner    <= winner;
                last     <= winner;
                err_flag <= 1'b0;
                gnt0     <= (winner == PORT0);
                gnt1     <= (winner == PORT1);
                fl_addr  <= (winner == PORT1) ? bus.ADDR1  : bus.ADDR0;
                fl_flow  <= (winner == PORT1) ? bus.FLOW1  : bus.FLOW0;
                fl_wdata <= (winner == PORT1) ? bus.WDATA1 : bus.WDATA0;
            end
            if (capture && !fl_flow) begin
                rdata <= bus.fl_data_in;
            end
            if (timeout) begin
                rdata    <= 8'hFF;
                err_flag <= 1'b1;
            end
            if (state == ST_DONE) begin
                gnt0 <= 1'b0;
                gnt1 <= 1'b0;
            end
        end
    end

    assign bus.GNT0        = gnt0;
    assign bus.GNT1        = gnt1;
    assign bus.DONE0       = (state == ST_DONE) && (owner == PORT0);
    assign bus.DONE1       = (state == ST_DONE) && (owner == PORT1);
    assign bus.ERR         = (state == ST_DONE) && err_flag;
    assign bus.RDATA       = rdata;
    assign bus.BUSY        = (state != ST_IDLE);
    assign bus.FL_ADDR     = fl_addr;
    assign bus.FL_FLOW     = fl_flow;
    assign bus.fl_data_out = fl_wdata;
    assign bus.FL_TRG      = (state == ST_ISSUE);

endmodule

// File: tb/tb_flash_arbiter.sv
// -----------------------------------------------------------------------------
// tb_flash_arbiter
// Self-checking bench for flash_arbiter (TIMEOUT_CYCLES = 16). A transaction
// level reference model tracks each transaction as "cycles since grant" and
// predicts every output each cycle; directed scenarios are followed by
// randomized traffic with spurious driver status and occasional resets.
// -----------------------------------------------------------------------------
module tb_flash_arbiter;

    localparam int T = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #10 clk = ~clk;

    flash_arb_if bus ();

    flash_arbiter #(
        .TIMEOUT_CYCLES (16'd16)
    ) dut (
        .CLK_50MHZ (clk),
        .RST       (rst),
        .bus       (bus)
    );

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    // Reference model: a transaction is in flight from its grant until the
    // completion cycle; m_age counts cycles since grant (1 = trigger cycle).
    bit       m_busy, m_fin, m_err, m_owner, m_last, m_flow;
    int       m_age;
    bit [7:0] m_rdata, m_addr, m_wdata;
    int       d_cur, next_delay;
    bit       auto_status, noise;

    // Observations of DUT behaviour for the directed scenarios.
    int       trg_cnt, done_seen, trg_age, done_lat;
    bit [7:0] done_rdata, done_addr, done_wd;
    bit       done_err, done_flow, prev_g0, prev_g1;
    int       grant_seq[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_fin = 0; m_err = 0; m_owner = 0; m_last = 1; m_flow = 0;
        m_age = 0; m_rdata = '0; m_addr = '0; m_wdata = '0;
    endtask

    task automatic model_step();
        bit w;
        if (!rst) begin
            model_reset();
        end else if (!m_busy) begin
            if (bus.REQ0 || bus.REQ1) begin
                w = (bus.REQ0 && bus.REQ1) ? !m_last : bus.REQ1;
                m_owner = w;
                m_last  = w;
                m_addr  = w ? bus.ADDR1  : bus.ADDR0;
                m_flow  = w ? bus.FLOW1  : bus.FLOW0;
                m_wdata = w ? bus.WDATA1 : bus.WDATA0;
                m_busy  = 1; m_fin = 0; m_err = 0; m_age = 1;
                d_cur   = next_delay;
            end
        end else if (m_fin) begin
            m_busy = 0; m_fin = 0;
        end else if (m_age == 1) begin
            m_age = 2;
        end else begin
            if (bus.FL_STATUS) begin
                if (!m_flow) m_rdata = bus.fl_data_in;
                m_fin = 1;
            end else if (m_age - 2 == T - 1) begin
                m_rdata = 8'hFF; m_err = 1; m_fin = 1;
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("gnt0",  bus.GNT0,  m_busy && m_owner == 0);
        check_eq("gnt1",  bus.GNT1,  m_busy && m_owner == 1);
        check_eq("done0", bus.DONE0, m_busy && m_fin && m_owner == 0);
        check_eq("done1", bus.DONE1, m_busy && m_fin && m_owner == 1);
        check_eq("err",   bus.ERR,   m_busy && m_fin && m_err);
        check_eq("trg",   bus.FL_TRG, m_busy && !m_fin && m_age == 1);
        check_eq("busy",  bus.BUSY,  m_busy);
        check_eq("rdata", bus.RDATA, m_rdata);
        check_eq("fl_addr", bus.FL_ADDR, m_addr);
        check_eq("fl_flow", bus.FL_FLOW, m_flow);
        check_eq("fl_wdata", bus.fl_data_out, m_wdata);
        check_eq("gnt_excl", bus.GNT0 & bus.GNT1, 0);
        if (bus.FL_TRG) begin
            trg_cnt++;
            trg_age = 0;
        end else begin
            trg_age++;
        end
        if (bus.GNT0 && !prev_g0) grant_seq.push_back(0);
        if (bus.GNT1 && !prev_g1) grant_seq.push_back(1);
        prev_g0 = bus.GNT0;
        prev_g1 = bus.GNT1;
        if (bus.DONE0 || bus.DONE1) begin
            done_seen++;
            done_rdata = bus.RDATA;
            done_err   = bus.ERR;
            done_addr  = bus.FL_ADDR;
            done_wd    = bus.fl_data_out;
            done_flow  = bus.FL_FLOW;
            done_lat   = trg_age;
        end
    endtask

    // One clock: the flash-driver responder drives FL_STATUS in the wait cycle
    // selected for this transaction, the model advances on the inputs that
    // the DUT samples at this edge, and outputs are compared mid-cycle.
    task automatic tick();
        if (auto_status)
            bus.FL_STATUS = (m_busy && !m_fin && m_age >= 2 && (m_age - 2) == d_cur) ||
                            (noise && $urandom_range(0, 15) == 0);
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run_until_idle(input int max_cycles);
        int n = 0;
        while (m_busy && n < max_cycles) begin
            tick();
            n++;
        end
        check_eq("idle_bound", m_busy, 0);
    endtask

    task automatic clear_obs();
        trg_cnt = 0; done_seen = 0; done_lat = -1;
        done_rdata = '0; done_err = 0; done_addr = '0; done_wd = '0; done_flow = 0;
    endtask

    initial begin
        bus.REQ0 = 0; bus.REQ1 = 0; bus.FLOW0 = 0; bus.FLOW1 = 0;
        bus.ADDR0 = '0; bus.ADDR1 = '0; bus.WDATA0 = '0; bus.WDATA1 = '0;
        bus.FL_STATUS = 0; bus.fl_data_in = '0;
        auto_status = 1; noise = 0; next_delay = 0; d_cur = 0; trg_age = 0;
        prev_g0 = 0; prev_g1 = 0;
        model_reset();
        clear_obs();
        @(negedge clk);

        // Reset state
        rst = 0;
        tick(); tick();
        rst = 1;

        // Read from port 0, status on the 4th wait cycle
        clear_obs();
        bus.REQ0 = 1; bus.FLOW0 = 0; bus.ADDR0 = 8'h12; bus.fl_data_in = 8'hA5;
        next_delay = 3;
        tick();
        bus.REQ0 = 0; bus.ADDR0 = 8'h99;
        run_until_idle(40);
        check_eq("rd_trg_cnt", trg_cnt, 1);
        check_eq("rd_done", done_seen, 1);
        check_eq("rd_rdata", done_rdata, 8'hA5);
        check_eq("rd_err", done_err, 0);
        check_eq("rd_addr", done_addr, 8'h12);
        check_eq("rd_lat", done_lat, 5);

        // Contention from reset: grants alternate starting with port 0
        rst = 0; tick(); rst = 1;
        grant_seq.delete();
        bus.REQ0 = 1; bus.REQ1 = 1; bus.FLOW0 = 0; bus.FLOW1 = 0; next_delay = 0;
        for (int n = 0; n < 60 && grant_seq.size() < 4; n++) tick();
        bus.REQ0 = 0; bus.REQ1 = 0;
        run_until_idle(40);
        check_eq("rr_count", grant_seq.size() >= 4, 1);
        for (int i = 0; i < 4 && i < grant_seq.size(); i++)
            check_eq("rr_order", grant_seq[i], i % 2);

        // Write from port 1, inputs changed right after the grant
        clear_obs();
        bus.REQ1 = 1; bus.FLOW1 = 1; bus.ADDR1 = 8'h40; bus.WDATA1 = 8'h3C;
        next_delay = 2;
        tick();
        bus.REQ1 = 0; bus.WDATA1 = 8'hC3; bus.FLOW1 = 0; bus.ADDR1 = 8'h00;
        bus.fl_data_in = 8'h5A;
        run_until_idle(40);
        check_eq("wr_done", done_seen, 1);
        check_eq("wr_wdata", done_wd, 8'h3C);
        check_eq("wr_flow", done_flow, 1);
        check_eq("wr_addr", done_addr, 8'h40);
        check_eq("wr_rdata", done_rdata, 8'hA5);

        // Watchdog timeout: driver never answers
        clear_obs();
        bus.REQ0 = 1; bus.FLOW0 = 0; bus.ADDR0 = 8'h07; next_delay = 255;
        tick();
        bus.REQ0 = 0;
        run_until_idle(60);
        check_eq("to_done", done_seen, 1);
        check_eq("to_err", done_err, 1);
        check_eq("to_rdata", done_rdata, 8'hFF);
        check_eq("to_lat", done_lat, T + 1);

        // Reset in the middle of WAIT, then a late driver status
        clear_obs();
        bus.REQ0 = 1; bus.ADDR0 = 8'h33; next_delay = 10;
        tick();
        bus.REQ0 = 0;
        for (int i = 0; i < 4; i++) tick();
        rst = 0; tick(); rst = 1;
        auto_status = 0; bus.FL_STATUS = 1; bus.fl_data_in = 8'h11;
        tick(); tick();
        bus.FL_STATUS = 0; auto_status = 1;
        check_eq("rst_no_done", done_seen, 0);
        bus.REQ0 = 1; bus.ADDR0 = 8'h21; bus.fl_data_in = 8'h66; next_delay = 1;
        tick();
        bus.REQ0 = 0;
        run_until_idle(40);
        check_eq("rst_next_done", done_seen, 1);
        check_eq("rst_next_rdata", done_rdata, 8'h66);
        check_eq("rst_next_err", done_err, 0);

        // Randomized traffic
        noise = 1;
        for (int n = 0; n < 1500; n++) begin
            bus.REQ0   = ($urandom_range(0, 2) == 0);
            bus.REQ1   = ($urandom_range(0, 2) == 0);
            bus.FLOW0  = $urandom_range(0, 1);
            bus.FLOW1  = $urandom_range(0, 1);
            bus.ADDR0  = 8'($urandom);
            bus.ADDR1  = 8'($urandom);
            bus.WDATA0 = 8'($urandom);
            bus.WDATA1 = 8'($urandom);
            bus.fl_data_in = 8'($urandom);
            next_delay = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 6));
            rst = ($urandom_range(0, 199) != 0);
            tick();
        end
        noise = 0; rst = 1; bus.REQ0 = 0; bus.REQ1 = 0;
        run_until_idle(60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
